// File: rtl/peripheral_bus_timer.sv
// Down-counting bus timer with periodic/one-shot expiry, sticky flag and irq; PERIPHERAL_TIMER_PRESCALER_EN adds PRESCALE at 0x010.
// Latency: writes land in one cycle; reads take two (busy in the first, registered data in the second).
// Backpressure: busy is the only wait request and is raised solely for the first cycle of a read.
module peripheral_bus_timer #(
    parameter logic [11:0] DEVICE_ADDRESS = 12'h000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        peripheralBus_we,
    input  logic        peripheralBus_oe,
    input  logic [23:0] peripheralBus_address,
    input  logic [3:0]  peripheralBus_byteSelect,
    input  logic [31:0] peripheralBus_dataWrite,
    output logic        peripheralBus_busy,
    output logic [31:0] peripheralBus_dataRead,
    output logic        timer_irq
);

    localparam logic [9:0] OFF_CONFIG   = 10'h000;
    localparam logic [9:0] OFF_RELOAD   = 10'h001;
    localparam logic [9:0] OFF_VALUE    = 10'h002;
    localparam logic [9:0] OFF_STATUS   = 10'h003;
    localparam logic [9:0] OFF_PRESCALE = 10'h004;

    logic        selected;
    logic [9:0]  reg_idx;
    logic        wr_en;
    logic        wr_config;
    logic        wr_reload;
    logic        wr_value;
    logic        wr_status;
    logic        wr_prescale;
    logic        rd_start;
    logic        tick;
    logic        expire;
    logic        unused_addr_bits;

    logic        cfg_enable;
    logic        cfg_one_shot;
    logic        cfg_irq_en;
    logic [31:0] reload_q;
    logic [31:0] value_q;
    logic        flag_q;
    logic        read_ready;
    logic [31:0] read_data;
    logic [31:0] rd_mux;
    logic [31:0] prescale_rd;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign selected         = (peripheralBus_address[23:12] == DEVICE_ADDRESS);
    assign reg_idx          = peripheralBus_address[11:2];
    assign unused_addr_bits = ^peripheralBus_address[1:0];

    assign wr_en       = selected && peripheralBus_we;
    assign wr_config   = wr_en && (reg_idx == OFF_CONFIG);
    assign wr_reload   = wr_en && (reg_idx == OFF_RELOAD);
    assign wr_value    = wr_en && (reg_idx == OFF_VALUE);
    assign wr_status   = wr_en && (reg_idx == OFF_STATUS);
    assign wr_prescale = wr_en && (reg_idx == OFF_PRESCALE);

    // A read is "started" only while no registered result is pending.
    assign rd_start = selected && peripheralBus_oe && !read_ready;
    assign expire   = tick && (value_q == 32'd0);

`ifdef PERIPHERAL_TIMER_PRESCALER_EN
    logic [15:0] prescale_q;
    logic [15:0] pre_cnt_q;

    assign tick        = cfg_enable && (pre_cnt_q == prescale_q);
    assign prescale_rd = {16'h0000, prescale_q};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            prescale_q <= 16'h0000;
            pre_cnt_q  <= 16'h0000;
        end else begin
            if (wr_prescale && peripheralBus_byteSelect[0]) prescale_q[7:0]  <= peripheralBus_dataWrite[7:0];
            if (wr_prescale && peripheralBus_byteSelect[1]) prescale_q[15:8] <= peripheralBus_dataWrite[15:8];
            // Restart the divider whenever its period or the timer mode changes.
            if (wr_prescale || wr_config) begin
                pre_cnt_q <= 16'h0000;
            end else if (cfg_enable) begin
                pre_cnt_q <= tick ? 16'h0000 : pre_cnt_q + 16'd1;
            end
        end
    end
`else
    logic unused_prescale;

    assign tick            = cfg_enable;
    assign prescale_rd     = 32'h0000_0000;
    assign unused_prescale = wr_prescale;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cfg_enable   <= 1'b0;
            cfg_one_shot <= 1'b0;
            cfg_irq_en   <= 1'b0;
            reload_q     <= 32'h0000_0000;
            value_q      <= 32'h0000_0000;
            flag_q       <= 1'b0;
        end else begin
            if (tick) begin
                if (value_q == 32'd0) begin
                    if (cfg_one_shot) cfg_enable <= 1'b0;
                    else              value_q    <= reload_q;
                end else begin
                    value_q <= value_q - 32'd1;
                end
            end
            // Bus writes come last so they override the counter's update.
            if (wr_value) value_q <= merge_bytes(value_q, peripheralBus_dataWrite, peripheralBus_byteSelect);
            if (wr_reload) reload_q <= merge_bytes(reload_q, peripheralBus_dataWrite, peripheralBus_byteSelect);
            if (wr_config && peripheralBus_byteSelect[0]) begin
                cfg_enable   <= peripheralBus_dataWrite[0];
                cfg_one_shot <= peripheralBus_dataWrite[1];
                cfg_irq_en   <= peripheralBus_dataWrite[2];
            end
            if (expire) begin
                flag_q <= 1'b1;
            end else if (wr_status && peripheralBus_byteSelect[0] && peripheralBus_dataWrite[0]) begin
                flag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 32'h0000_0000;
        case (reg_idx)
            OFF_CONFIG:   rd_mux = {29'd0, cfg_irq_en, cfg_one_shot, cfg_enable};
            OFF_RELOAD:   rd_mux = reload_q;
            OFF_VALUE:    rd_mux = value_q;
            OFF_STATUS:   rd_mux = {31'd0, flag_q};
            OFF_PRESCALE: rd_mux = prescale_rd;
            default:      rd_mux = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            read_ready <= 1'b0;
            read_data  <= 32'h0000_0000;
        end else begin
            read_ready <= rd_start;
            if (rd_start) read_data <= rd_mux;
        end
    end

    assign peripheralBus_busy     = wb_rst_n && rd_start;
    assign peripheralBus_dataRead = (wb_rst_n && read_ready && selected) ? read_data : 32'h0000_0000;
    assign timer_irq              = flag_q && cfg_irq_en;

endmodule

// File: tb/tb_peripheral_bus_timer.sv
// Bench for peripheral_bus_timer: bus-level stimulus, read results checked through an expected-value queue.
module tb_peripheral_bus_timer;

    localparam logic [11:0] DEV = 12'h123;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        bus_we;
    logic        bus_oe;
    logic [23:0] bus_address;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdat;
    logic        bus_busy;
    logic [31:0] bus_rdat;
    logic        timer_irq;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    peripheral_bus_timer #(.DEVICE_ADDRESS(DEV)) dut (
        .wb_clk_i                 (wb_clk_i),
        .wb_rst_n                 (wb_rst_n),
        .peripheralBus_we         (bus_we),
        .peripheralBus_oe         (bus_oe),
        .peripheralBus_address    (bus_address),
        .peripheralBus_byteSelect (bus_be),
        .peripheralBus_dataWrite  (bus_wdat),
        .peripheralBus_busy       (bus_busy),
        .peripheralBus_dataRead   (bus_rdat),
        .timer_irq                (timer_irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ra(input logic [11:0] off);
        return {DEV, off};
    endfunction

    // All tasks start and end 1 ns after a rising edge.
    task automatic bus_write(input logic [23:0] addr, input logic [3:0] be, input logic [31:0] data);
        bus_address = addr;
        bus_be      = be;
        bus_wdat    = data;
        bus_we      = 1'b1;
        @(negedge wb_clk_i);
        check("wr_busy", bus_busy, 32'd0);
        @(posedge wb_clk_i);
        #1;
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [23:0] addr, input logic [31:0] exp);
        logic        sel;
        logic [31:0] e;
        sel = (addr[23:12] == DEV);
        exp_q.push_back(sel ? exp : 32'd0);
        bus_address = addr;
        bus_oe      = 1'b1;
        @(negedge wb_clk_i);
        check({tag, "_busy1"}, bus_busy, {31'd0, sel});
        check({tag, "_data1"}, bus_rdat, 32'd0);
        @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        check({tag, "_busy2"}, bus_busy, 32'd0);
        e = exp_q.pop_front();
        check(tag, bus_rdat, e);
        @(posedge wb_clk_i);
        #1;
        bus_oe = 1'b0;
    endtask

    task automatic idle_irq(input string tag, input logic exp_irq);
        @(negedge wb_clk_i);
        check(tag, timer_irq, {31'd0, exp_irq});
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_n    = 1'b0;
        bus_we      = 1'b0;
        bus_oe      = 1'b1;
        bus_address = ra(12'h008);
        bus_be      = 4'h0;
        bus_wdat    = 32'h0;
        #3;
        check("rst_busy", bus_busy, 32'd0);
        check("rst_rdat", bus_rdat, 32'd0);
        check("rst_irq", timer_irq, 32'd0);
        bus_oe = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        @(posedge wb_clk_i);
        #1;

        bus_read("rst_config", ra(12'h000), 32'h0);
        bus_read("rst_reload", ra(12'h004), 32'h0);
        bus_read("rst_value",  ra(12'h008), 32'h0);
        bus_read("rst_status", ra(12'h00C), 32'h0);

        // Byte lanes
        bus_write(ra(12'h004), 4'hF, 32'h0);
        bus_write(ra(12'h004), 4'b0010, 32'hAABBCCDD);
        bus_read("lane_b1", ra(12'h004), 32'h0000CC00);
        bus_write(ra(12'h004), 4'b1001, 32'h11223344);
        bus_read("lane_b03", ra(12'h006), 32'h1100CC44);

        // Unmapped, prescale absent, foreign device, reserved CONFIG bits
        bus_write(ra(12'h010), 4'hF, 32'hFFFFFFFF);
        bus_read("prescale_off", ra(12'h010), 32'h0);
        bus_write(ra(12'h014), 4'hF, 32'h12345678);
        bus_read("unmapped", ra(12'h014), 32'h0);
        bus_write({12'h456, 12'h004}, 4'hF, 32'hDEADBEEF);
        bus_read("foreign_rd", {12'h456, 12'h004}, 32'h0);
        bus_read("foreign_wr", ra(12'h004), 32'h1100CC44);
        bus_write(ra(12'h000), 4'hF, 32'hFFFFFFF8);
        bus_read("cfg_rsvd", ra(12'h000), 32'h0);

        // Periodic: RELOAD=3 gives a 4-cycle period
        bus_write(ra(12'h004), 4'hF, 32'd3);
        bus_write(ra(12'h008), 4'hF, 32'd3);
        bus_write(ra(12'h000), 4'hF, 32'h5);
        for (int i = 0; i < 4; i++) idle_irq("per_irq_lo", 1'b0);
        idle_irq("per_irq_hi", 1'b1);
        bus_read("per_v2a", ra(12'h008), 32'd2);
        bus_read("per_v0a", ra(12'h008), 32'd0);
        bus_read("per_v2b", ra(12'h008), 32'd2);
        bus_read("per_v0b", ra(12'h008), 32'd0);
        bus_write(ra(12'h000), 4'hF, 32'h0);
        bus_read("per_flag", ra(12'h00C), 32'd1);
        bus_write(ra(12'h00C), 4'hF, 32'd1);
        bus_read("per_clr", ra(12'h00C), 32'd0);

        // RELOAD=0: expiry every tick, set beats same-cycle clear
        bus_write(ra(12'h004), 4'hF, 32'd0);
        bus_write(ra(12'h008), 4'hF, 32'd0);
        bus_write(ra(12'h000), 4'hF, 32'h5);
        idle_irq("r0_irq_lo", 1'b0);
        idle_irq("r0_irq_hi", 1'b1);
        bus_write(ra(12'h00C), 4'hF, 32'd1);
        idle_irq("r0_set_wins", 1'b1);
        bus_write(ra(12'h000), 4'hF, 32'h4);
        bus_write(ra(12'h00C), 4'hF, 32'd1);
        idle_irq("r0_cleared", 1'b0);
        bus_read("r0_status", ra(12'h00C), 32'd0);
        bus_read("r0_config", ra(12'h000), 32'h4);

        // One-shot
        bus_write(ra(12'h008), 4'hF, 32'd2);
        bus_write(ra(12'h000), 4'hF, 32'h3);
        bus_read("os_v2", ra(12'h008), 32'd2);
        bus_read("os_flag_early", ra(12'h00C), 32'd0);
        bus_read("os_flag", ra(12'h00C), 32'd1);
        bus_read("os_config", ra(12'h000), 32'h2);
        bus_read("os_value", ra(12'h008), 32'd0);
        idle_irq("os_irq_masked", 1'b0);
        bus_read("os_hold", ra(12'h008), 32'd0);

        // Asynchronous reset mid-count and mid-read
        bus_write(ra(12'h00C), 4'hF, 32'd1);
        bus_write(ra(12'h004), 4'hF, 32'd5);
        bus_write(ra(12'h008), 4'hF, 32'd5);
        bus_write(ra(12'h000), 4'hF, 32'h5);
        for (int i = 0; i < 6; i++) idle_irq("ar_irq_lo", 1'b0);
        idle_irq("ar_irq_hi", 1'b1);
        bus_address = ra(12'h008);
        bus_oe      = 1'b1;
        @(negedge wb_clk_i);
        check("ar_pre_busy", bus_busy, 32'd1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        check("ar_irq", timer_irq, 32'd0);
        check("ar_busy", bus_busy, 32'd0);
        check("ar_rdat", bus_rdat, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        check("ar_fresh_busy", bus_busy, 32'd1);
        @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        check("ar_fresh_busy2", bus_busy, 32'd0);
        check("ar_fresh_value", bus_rdat, exp_q.pop_front());
        @(posedge wb_clk_i);
        #1;
        bus_oe = 1'b0;
        bus_read("ar_config", ra(12'h000), 32'h0);
        bus_read("ar_reload", ra(12'h004), 32'h0);
        bus_read("ar_status", ra(12'h00C), 32'h0);
        idle_irq("ar_irq_after", 1'b0);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
